// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the main-memory responder.
package mem_resp_pkg;

  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    TURN = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/mem_line_array.sv
// Single-port line store: synchronous write, registered read, contents never reset.
module mem_line_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem_q [2**ADDR_W];
  logic [LINE_W-1:0] rd_data_q;

  // One access per cycle; the read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end else if (re) begin
      rd_data_q <= mem_q[addr];
    end
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: one line read/write at a time, fixed latency, one-cycle mem_ready.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY        = 4,
  parameter int LINE_ADDR_BITS = 6
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  proto_err
);

  localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [LINE_ADDR_BITS-1:0] idx_q, idx_d;
  logic [LINE_W-1:0]         wdata_q, wdata_d;
  logic                      perr_q, perr_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      rvalid_q, rvalid_d;

  logic                      arr_we_s, arr_re_s;
  logic [LINE_ADDR_BITS-1:0] arr_idx_s;
  logic [LINE_W-1:0]         arr_wdata_s;
  logic [LINE_W-1:0]         arr_rdata_s;
  logic                      addr_unused_s;

  assign addr_unused_s = ^mem_addr[MEM_ADDR_W-1:LINE_ADDR_BITS];

  // Next-state, counter and array-access decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    perr_d      = perr_q;
    arr_we_s    = 1'b0;
    arr_re_s    = 1'b0;
    arr_idx_s   = idx_q;
    arr_wdata_s = wdata_q;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          op_d    = mem_write ? OP_WR : OP_RD;
          idx_d   = mem_addr[LINE_ADDR_BITS-1:0];
          wdata_d = mem_wdata;
          if (mem_read && mem_write) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
          // With unit latency the accepting edge is also the edge entering RESP.
          if (LATENCY == 1) begin
            state_d     = RESP;
            arr_idx_s   = mem_addr[LINE_ADDR_BITS-1:0];
            arr_wdata_s = mem_wdata;
            arr_we_s    = mem_write;
            arr_re_s    = ~mem_write;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d  = RESP;
          arr_we_s = (op_q == OP_WR);
          arr_re_s = (op_q == OP_RD);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (proc_reset) begin
      arr_we_s = 1'b0;
      arr_re_s = 1'b0;
    end else begin
      arr_we_s = arr_we_s;
      arr_re_s = arr_re_s;
    end

    rvalid_d = rvalid_q | arr_re_s;
    ready_d  = (state_d == RESP);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      wdata_q  <= '0;
      perr_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      perr_q   <= perr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
    end
  end

  mem_line_array #(
    .ADDR_W(LINE_ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we_s),
    .re   (arr_re_s),
    .addr (arr_idx_s),
    .wdata(arr_wdata_s),
    .rdata(arr_rdata_s)
  );

  // The array read register is not reset, so it is masked until a read has landed.
  assign mem_rdata = rvalid_q ? arr_rdata_s : '0;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut 0 runs LATENCY=4, dut 1 runs LATENCY=1.
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         rst_s   [2];
  logic         rd_s    [2];
  logic         wr_s    [2];
  logic [27:0]  addr_s  [2];
  logic [127:0] wdata_s [2];
  logic [127:0] rdata_s [2];
  logic         ready_s [2];
  logic         busy_s  [2];
  logic         perr_s  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4), .LINE_ADDR_BITS(6)) dut0 (
    .clk(clk), .proc_reset(rst_s[0]), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]), .mem_rdata(rdata_s[0]),
    .mem_ready(ready_s[0]), .busy(busy_s[0]), .proto_err(perr_s[0])
  );

  mem_responder #(.LATENCY(1), .LINE_ADDR_BITS(6)) dut1 (
    .clk(clk), .proc_reset(rst_s[1]), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]), .mem_rdata(rdata_s[1]),
    .mem_ready(ready_s[1]), .busy(busy_s[1]), .proto_err(perr_s[1])
  );

  typedef struct {
    bit           rd;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  localparam logic [127:0] D5   = 128'h01234567_89ABCDEF_CAFEF00D_DEADBEEF;
  localparam logic [127:0] D3   = 128'h33333333_30303030_03030303_00000003;
  localparam logic [127:0] D5B  = 128'h55555555_5A5A5A5A_A5A5A5A5_0000005B;
  localparam logic [127:0] DTOP = 128'hFFFF0000_0000FFFF_12345678_0000003F;
  localparam logic [127:0] D9   = 128'h99999999_90909090_09090909_00000009;
  localparam logic [127:0] D3B  = 128'hBBBBBBBB_B3B3B3B3_3B3B3B3B_0000003B;
  localparam logic [127:0] D11  = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] DAA  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] DB   = 128'h0BADC0DE_0BADC0DE_0BADC0DE_00000040;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One transaction; lat is the posedge count (from the first edge after driving) at which mem_ready is seen.
  task automatic txn(input int d, input bit r, input bit w, input logic [27:0] a,
                     input logic [127:0] wd, input int pre,
                     output int lat, output logic [127:0] rdat);
    repeat (pre) @(negedge clk);
    @(negedge clk);
    rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
    lat  = -1;
    rdat = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready_s[d]) begin
        lat  = k;
        rdat = rdata_s[d];
        break;
      end
    end
    @(negedge clk);
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
  endtask

  vec_t         vecs [9];
  int           lat;
  logic [127:0] rdat;
  int           ready_seen;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 28'h0000005, 128'h0, D5};
    vecs[1] = '{1'b0, 1'b1, 28'h0000003, D3,     D5};
    vecs[2] = '{1'b1, 1'b0, 28'h0000003, 128'h0, D3};
    vecs[3] = '{1'b0, 1'b1, 28'h0000045, D5B,    D3};
    vecs[4] = '{1'b1, 1'b0, 28'h0000005, 128'h0, D5B};
    vecs[5] = '{1'b0, 1'b1, 28'hFFFFFFF, DTOP,   D5B};
    vecs[6] = '{1'b1, 1'b0, 28'h000003F, 128'h0, DTOP};
    vecs[7] = '{1'b0, 1'b1, 28'h0000009, D9,     DTOP};
    vecs[8] = '{1'b1, 1'b0, 28'h0000009, 128'h0, D9};

    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      addr_s[d] = 28'h0; wdata_s[d] = 128'h0;
    end
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    @(posedge clk); #1;
    chk("reset_ready", {127'h0, ready_s[0]}, 128'h0);
    chk("reset_busy",  {127'h0, busy_s[0]},  128'h0);
    chk("reset_rdata", rdata_s[0],           128'h0);
    chk("reset_perr",  {127'h0, perr_s[0]},  128'h0);

    // First write: cycle-by-cycle ready and busy profile.
    @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 28'h0000005; wdata_s[0] = D5;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("w5_ready_c%0d", c), {127'h0, ready_s[0]}, {127'h0, (c == 4)});
      if (c <= 5) chk($sformatf("w5_busy_c%0d", c), {127'h0, busy_s[0]}, 128'h1);
      if (c == 4) begin
        @(negedge clk);
        wr_s[0] = 1'b0;
      end
    end
    chk("w5_rdata_unchanged", rdata_s[0], 128'h0);

    for (int i = 0; i < 9; i++) begin
      txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1, lat, rdat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
      chk($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
      @(negedge clk);
      chk($sformatf("vec%0d_rdata_held", i), rdata_s[0], vecs[i].exp_rdata);
      chk($sformatf("vec%0d_perr", i), {127'h0, perr_s[0]}, 128'h0);
    end

    // Write-back then allocate: read raised while the responder is in TURN.
    txn(0, 1'b0, 1'b1, 28'h0000003, D3B, 1, lat, rdat);
    chk("wb_latency", 128'(lat), 128'd4);
    txn(0, 1'b1, 1'b0, 28'h0000003, 128'h0, 0, lat, rdat);
    chk("alloc_latency_after_turn", 128'(lat), 128'd5);
    chk("alloc_rdata", rdat, D3B);
    chk("alloc_perr", {127'h0, perr_s[0]}, 128'h0);

    // Simultaneous read and write: write wins, flag is sticky.
    txn(0, 1'b1, 1'b1, 28'h0000007, D11, 1, lat, rdat);
    chk("both_latency", 128'(lat), 128'd4);
    chk("both_rdata_unchanged", rdat, D3B);
    chk("both_perr", {127'h0, perr_s[0]}, 128'h1);
    txn(0, 1'b1, 1'b0, 28'h0000007, 128'h0, 1, lat, rdat);
    chk("both_line_written", rdat, D11);
    chk("both_perr_sticky", {127'h0, perr_s[0]}, 128'h1);

    // Reset during BUSY of a write discards it.
    repeat (2) @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 28'h0000009; wdata_s[0] = DAA;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_s[0] = 1'b1; wr_s[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy",  {127'h0, busy_s[0]},  128'h0);
    chk("rst_ready", {127'h0, ready_s[0]}, 128'h0);
    chk("rst_perr",  {127'h0, perr_s[0]},  128'h0);
    chk("rst_rdata", rdata_s[0],           128'h0);
    @(negedge clk);
    rst_s[0] = 1'b0;
    ready_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ready_s[0]) ready_seen++;
    end
    chk("rst_no_ready", 128'(ready_seen), 128'd0);
    txn(0, 1'b1, 1'b0, 28'h0000009, 128'h0, 1, lat, rdat);
    chk("rst_prior_contents", rdat, D9);
    chk("rst_read_latency", 128'(lat), 128'd4);

    // Unit latency and address aliasing above the index bits.
    txn(1, 1'b0, 1'b1, 28'h0000040, DB, 1, lat, rdat);
    chk("lat1_write_latency", 128'(lat), 128'd1);
    txn(1, 1'b1, 1'b0, 28'h0000000, 128'h0, 1, lat, rdat);
    chk("lat1_read_latency", 128'(lat), 128'd1);
    chk("lat1_alias_rdata", rdat, DB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
